alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-channel arbiter and sequencer for the shared 8-bit combinational ALU; the ALU ports are operand_a, operand_b, operation, result and carry_out. Two requesters each submit {a, b, op} commands over a valid/ready handshake. The block grants the ALU round-robin, registers the operands into the ALU, captures result and carry, and returns them on that channel's response handshake. It sits between the requesting engines and the single ALU instance, so only one operation is in flight at a time.

## Interface
- CNT_W, 16, width of the per-channel completed-operation counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  channel command valid
- req0_ready / req1_ready  out  1  channel command accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  8  channel operands
- req0_op / req1_op  in  4  channel ALU opcode, passed unmodified
- rsp0_valid / rsp1_valid  out  1  channel response valid
- rsp0_ready / rsp1_ready  in  1  channel response consumed
- rsp_result  out  8  captured ALU result, shared by both channels, meaningful when an rspN_valid is high
- rsp_carry  out  1  captured ALU carry_out
- rsp_dz  out  1  divide-by-zero flag: op==4'b0011 and b==0
- alu_a, alu_b  out  8  to ALU operand_a / operand_b (registered)
- alu_op  out  4  to ALU operation (registered)
- alu_result  in  8  from ALU result
- alu_carry  in  1  from ALU carry_out
- busy  out  1  high in any state except IDLE
- cnt0, cnt1  out  CNT_W  completed responses per channel, saturating

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: ALU inputs stable for one cycle.
  - RESP: response held.
- IDLE:
  - Grant = valid channel. If both channels are valid, grant goes to the priority pointer `prio` (0 or 1).
  - reqN_ready = (state==IDLE) & grantN. The ready is combinational from valid and prio.
  - At most one ready is high per cycle. No ready is high outside IDLE.
- On accept:
  - Latch a, b, op into alu_a/alu_b/alu_op.
  - Latch owner = granted channel and dz = (op==4'b0011 && b==8'd0).
  - Set prio = ~owner.
  - Go to EXEC.
- EXEC (exactly 1 cycle):
  - Capture alu_result → rsp_result and alu_carry → rsp_carry.
  - Go to RESP.
- RESP:
  - rsp{owner}_valid = 1. The other channel's rsp valid is 0.
  - rsp_result, rsp_carry and rsp_dz stay stable until the handshake completes.
  - On rsp{owner}_ready: increment cnt{owner}, saturating at all-ones, and go to IDLE.
  - The other channel's rsp_ready is ignored.
- alu_a/alu_b/alu_op hold their last accepted values while in IDLE. They do not return to zero.
- The opcode is not decoded beyond the dz check. All 16 opcodes pass through.
- The ALU's carry rule is not re-derived: the ALU drives carry only for ADD and 0 otherwise, and rsp_carry is exactly the captured alu_carry.

## Timing
- Reset values (async on rst_n low):
  - state=IDLE, prio=0, owner=0.
  - alu_a=alu_b=0, alu_op=0.
  - rsp_result=0, rsp_carry=0, rsp_dz=0.
  - rsp0/1_valid=0, busy=0, cnt0=cnt1=0.
  - reqN_ready may be high during reset only if reqN_valid is high. Nothing is accepted while rst_n is low.
- Reset mid-operation aborts the in-flight command with no response and no counter increment. After release, arbitration restarts with prio=0.
- Latency, with the accept edge at cycle N:
  - EXEC in N+1.
  - Result captured at the end of N+1.
  - rspN_valid high from N+2.
- Minimum accept-to-accept spacing is 3 cycles with rsp_ready held high: accept N, response completes at the end of N+2, next accept N+3.
- Back-pressure: rsp_ready low holds RESP indefinitely. Both req_ready stay 0 during that time.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1…
- With one requester valid, that channel is granted regardless of prio. prio still updates to the other channel.
- Requesters must hold valid and data until ready; dropping valid before accept is permitted. A requester may change data while its ready is 0.
- Counter saturation: at 2^CNT_W−1 a further completion leaves the count unchanged.

## Test plan
- Reset, then ch0 sends a=8'd200, b=8'd100, op=4'b0000 → req0_ready in the accept cycle; rsp0_valid 2 cycles later with rsp_result=8'd44, rsp_carry=1, rsp_dz=0; cnt0=1.
- Both channels valid continuously with rsp_ready=1: ch0 a=5,b=3,op=0001, ch1 a=6,b=7,op=0010 → grants alternate 0,1,0,1, one accept every 3 cycles; results 8'd2 (ch0) and 8'd42 (ch1).
- ch1 op=4'b0011, a=9, b=0 → rsp_result=0, rsp_dz=1. Then ch1 a=9, b=2 → rsp_result=4, rsp_dz=0.
- Back-pressure: rsp0_ready=0 for 5 cycles with ch1 valid → rsp0_valid and rsp_result held stable; req1_ready=0 throughout; ch1 is accepted in the cycle after rsp0_ready rises and the response completes.
- Assert rst_n low in EXEC → all outputs at reset values immediately; no rsp_valid after release; cnt unchanged at 0; the next accept goes to ch0 when both are valid.
- Simulate with CNT_W=2 and 5 ch0 completions → cnt0 sequence 1,2,3,3,3.

Source files
------------

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_ctrl
// Brief    : Round-robin arbiter and sequencer sharing one combinational ALU
//            between two valid/ready command channels.
// Revision : 1.0
// ============================================================================
module alu_share_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_dz,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_op,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [3:0] c_op_div = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;
    logic             r_owner;
    logic [7:0]       r_alu_a;
    logic [7:0]       r_alu_b;
    logic [3:0]       r_alu_op;
    logic [7:0]       r_result;
    logic             r_carry;
    logic             r_dz;
    logic [CNT_W-1:0] r_cnt [2];

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_rsp_done;
    logic [7:0]       w_sel_a;
    logic [7:0]       w_sel_b;
    logic [3:0]       w_sel_op;

    // A lone requester wins regardless of prio; prio only breaks ties.
    assign w_grant0   = req0_valid & (~req1_valid | ~r_prio);
    assign w_grant1   = req1_valid & (~req0_valid |  r_prio);
    assign req0_ready = (r_state == IDLE) & w_grant0;
    assign req1_ready = (r_state == IDLE) & w_grant1;
    assign w_accept   = req0_ready | req1_ready;

    assign w_sel_a    = w_grant1 ? req1_a  : req0_a;
    assign w_sel_b    = w_grant1 ? req1_b  : req0_b;
    assign w_sel_op   = w_grant1 ? req1_op : req0_op;

    assign w_rsp_done = (r_state == RESP) & (r_owner ? rsp1_ready : rsp0_ready);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = EXEC;
            EXEC:                    w_state_nxt = RESP;
            RESP:    if (w_rsp_done) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_alu_a  <= 8'd0;
            r_alu_b  <= 8'd0;
            r_alu_op <= 4'd0;
            r_result <= 8'd0;
            r_carry  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_op <= w_sel_op;
                r_owner  <= w_grant1;
                r_prio   <= ~w_grant1;
                r_dz     <= (w_sel_op == c_op_div) && (w_sel_b == 8'd0);
            end
            if (r_state == EXEC) begin
                r_result <= alu_result;
                r_carry  <= alu_carry;
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_cnt
        localparam logic c_ch = (i != 0);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[i] <= '0;
            end else if (w_rsp_done && (r_owner == c_ch) && (r_cnt[i] != '1)) begin
                r_cnt[i] <= r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign rsp0_valid = (r_state == RESP) & ~r_owner;
    assign rsp1_valid = (r_state == RESP) &  r_owner;
    assign rsp_result = r_result;
    assign rsp_carry  = r_carry;
    assign rsp_dz     = r_dz;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign busy       = (r_state != IDLE);
    assign cnt0       = r_cnt[0];
    assign cnt1       = r_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_ctrl
// Brief    : Scoreboard bench for alu_share_ctrl with a behavioural ALU.
// Revision : 1.0
// ============================================================================
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
    logic [3:0] req0_op = 4'd0, req1_op = 4'd0;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0]  rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_carry, rsp_dz, alu_carry, busy;
    logic [3:0]  alu_op;
    logic [15:0] cnt0, cnt1;

    logic        s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid;
    logic [7:0]  s_rsp_result, s_alu_a, s_alu_b;
    logic        s_rsp_carry, s_rsp_dz, s_busy;
    logic [3:0]  s_alu_op;
    logic [1:0]  s_cnt0, s_cnt1;

    always #5 clk = ~clk;

    // ALU: carry only for ADD
    always_comb begin
        alu_carry  = 1'b0;
        alu_result = alu_a ^ alu_b;
        case (alu_op)
            4'b0000: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = 8'((16'(alu_a) * 16'(alu_b)));
            4'b0011: alu_result = (alu_b == 8'd0) ? 8'd0 : alu_a / alu_b;
            default: ;
        endcase
    end

    alu_share_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_dz(rsp_dz),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_carry(alu_carry),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    // Narrow-counter twin sees identical stimulus and ALU data.
    alu_share_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(s_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(s_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(s_rsp_result), .rsp_carry(s_rsp_carry), .rsp_dz(s_rsp_dz),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op), .alu_result(alu_result), .alu_carry(alu_carry),
        .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    typedef struct {
        int         ch;
        logic [7:0] res;
        logic       c;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_cnt0 = 0, m_cnt1 = 0;
    int   m_ch;
    int   acc_cyc = 0, prev_acc = -1;
    bit   chk_space = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle invariants, counter model and scoreboard pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            check("cnt0", 32'(cnt0), m_cnt0);
            check("cnt1", 32'(cnt1), m_cnt1);
            check("cnt0_sat", 32'(s_cnt0), (m_cnt0 > 3) ? 3 : m_cnt0);
            check("cnt1_sat", 32'(s_cnt1), (m_cnt1 > 3) ? 3 : m_cnt1);
            check("two_ready", 32'(req0_ready & req1_ready), 0);
            check("ready_busy", 32'((req0_ready | req1_ready) & busy), 0);
            check("two_rsp_valid", 32'(rsp0_valid & rsp1_valid), 0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                m_ch = rsp1_valid ? 1 : 0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got response on ch%0d, want none", m_ch);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_ch", m_ch, e.ch);
                    check("rsp_result", 32'(rsp_result), 32'(e.res));
                    check("rsp_carry", 32'(rsp_carry), 32'(e.c));
                    check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
                end
                if (m_ch == 1) m_cnt1++;
                else           m_cnt0++;
            end
        end
    end

    // Drive one command; returns #1 after the accept edge (DUT in EXEC).
    task automatic drive(input int ch, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int   n = 0;
        logic rdy;
        if (ch == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        else         begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        do begin
            @(negedge clk);
            n++;
            rdy = (ch == 0) ? req0_ready : req1_ready;
        end while (!rdy && n < 40);
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ch%0d not accepted, want accept within 40 cycles", ch);
        end else begin
            acc_cyc = cyc;
            if (chk_space && prev_acc >= 0) check("accept_spacing", acc_cyc - prev_acc, 3);
            prev_acc = acc_cyc;
        end
        @(posedge clk);
        #1;
        if (ch == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
        if (rdy) begin
            check("alu_a", 32'(alu_a), 32'(a));
            check("alu_b", 32'(alu_b), 32'(b));
            check("alu_op", 32'(alu_op), 32'(op));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 40);
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=1, want 0 within 40 cycles");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rsp_valid"}, 32'({rsp0_valid, rsp1_valid}), 0);
        check({tag, "_alu"}, {12'd0, alu_a, alu_b, alu_op}, 0);
        check({tag, "_rsp"}, {22'd0, rsp_result, rsp_carry, rsp_dz}, 0);
        check({tag, "_cnt"}, {cnt0, cnt1}, 0);
        check({tag, "_ready"}, 32'({req0_ready, req1_ready}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    int m;
    int sat_seq[5] = '{1, 2, 3, 3, 3};

    initial begin
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        // Single ADD with carry, exact latency
        sb.push_back('{0, 8'd44, 1'b1, 1'b0});
        drive(0, 8'd200, 8'd100, 4'b0000);
        check("t1_exec_valid", 32'(rsp0_valid), 0);
        check("t1_exec_busy", 32'(busy), 1);
        @(posedge clk); #1;
        check("t1_rsp_valid", 32'(rsp0_valid), 1);
        check("t1_rsp_result", 32'(rsp_result), 44);
        @(posedge clk); #1;
        check("t1_idle", 32'(busy), 0);
        check("t1_cnt0", 32'(cnt0), 1);

        // Divide by zero, then a normal divide
        sb.push_back('{1, 8'd0, 1'b0, 1'b1});
        drive(1, 8'd9, 8'd0, 4'b0011);
        wait_idle();
        sb.push_back('{1, 8'd4, 1'b0, 1'b0});
        drive(1, 8'd9, 8'd2, 4'b0011);
        wait_idle();

        // Both channels valid continuously: strict alternation, 3-cycle spacing
        sb.push_back('{0, 8'd2, 1'b0, 1'b0});
        sb.push_back('{1, 8'd42, 1'b0, 1'b0});
        sb.push_back('{0, 8'd2, 1'b0, 1'b0});
        sb.push_back('{1, 8'd42, 1'b0, 1'b0});
        chk_space = 1'b1;
        prev_acc = -1;
        fork
            begin repeat (2) drive(0, 8'd5, 8'd3, 4'b0001); end
            begin repeat (2) drive(1, 8'd6, 8'd7, 4'b0010); end
        join
        chk_space = 1'b0;
        wait_idle();

        // Response back-pressure on ch0 with ch1 waiting
        rsp0_ready = 1'b0;
        sb.push_back('{0, 8'd25, 1'b0, 1'b0});
        drive(0, 8'd50, 8'd25, 4'b0001);
        @(posedge clk); #1;
        sb.push_back('{1, 8'd30, 1'b0, 1'b0});
        req1_a = 8'd10; req1_b = 8'd20; req1_op = 4'b0000; req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp0_valid", 32'(rsp0_valid), 1);
            check("bp_result", 32'(rsp_result), 25);
            check("bp_req1_ready", 32'(req1_ready), 0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_req1_ready_resp", 32'(req1_ready), 0);
        m = cyc;
        drive(1, 8'd10, 8'd20, 4'b0000);
        check("bp_accept_cycle", acc_cyc, m + 1);
        wait_idle();

        // Reset while in EXEC aborts the command and clears prio
        drive(0, 8'd1, 8'd1, 4'b0000);
        check("rst_exec_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_rsp", 32'({rsp0_valid, rsp1_valid, busy}), 0);
        end
        @(posedge clk); #1;
        sb.push_back('{0, 8'd7, 1'b0, 1'b0});
        sb.push_back('{1, 8'd0, 1'b1, 1'b0});
        fork
            drive(0, 8'd3, 8'd4, 4'b0000);
            drive(1, 8'hFF, 8'h01, 4'b0000);
        join
        wait_idle();

        // Counter saturation on the CNT_W=2 twin, assorted opcodes
        rst_n = 1'b0;
        #1;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin sb.push_back('{0, 8'hFF, 1'b0, 1'b0}); drive(0, 8'hF0, 8'h0F, 4'b1111); end
                1: begin sb.push_back('{0, 8'h06, 1'b0, 1'b0}); drive(0, 8'h0C, 8'h0A, 4'b0100); end
                2: begin sb.push_back('{0, 8'h04, 1'b0, 1'b0}); drive(0, 8'h07, 8'h03, 4'b0001); end
                3: begin sb.push_back('{0, 8'h00, 1'b1, 1'b0}); drive(0, 8'h80, 8'h80, 4'b0000); end
                default: begin sb.push_back('{0, 8'h00, 1'b0, 1'b1}); drive(0, 8'h10, 8'h00, 4'b0011); end
            endcase
            wait_idle();
            check("sat_cnt0", 32'(s_cnt0), sat_seq[i]);
        end
        check("final_cnt0", 32'(cnt0), 5);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
